// File: rtl/pwm_duty_decoder.sv
// PWM receive decoder: measures high time and period between rising edges of a
// synchronised PWM stream and converts them to a WIDTH-bit duty with a serial divider.
module pwm_duty_decoder #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             duty_valid,
  output logic             stuck,
  output logic             overrun
);

  localparam int SW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [SYNC_STAGES:0]   r_prime;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_hcnt;
  logic [CNT_W-1:0]       r_lcnt;
  logic [CNT_W-1:0]       r_idle;

  logic                   r_busy;
  logic [SW-1:0]          r_step;
  logic [CNT_W-1:0]       r_rem;
  logic [CNT_W-1:0]       r_div;
  logic [CNT_W-1:0]       r_ht;
  logic [WIDTH-1:0]       r_quo;

  logic [WIDTH-1:0]       r_duty;
  logic [CNT_W-1:0]       r_high_time;
  logic [CNT_W-1:0]       r_period;
  logic                   r_duty_valid;
  logic                   r_stuck;
  logic                   r_overrun;

  logic                   w_s;
  logic                   w_primed;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_edge;
  logic                   w_timeout;
  logic                   w_complete;
  logic [CNT_W-1:0]       w_per;
  logic [CNT_W:0]         w_sh;
  logic                   w_ge;

  // Edges are ignored until the chain and its delayed copy hold real input
  // samples, so a line already high at reset release is not taken as a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_s_d   <= 1'b0;
      r_prime <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d   <= r_sync[SYNC_STAGES-1];
      r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_primed   = r_prime[SYNC_STAGES];
  assign w_rise     = w_primed & w_s & ~r_s_d;
  assign w_fall     = w_primed & ~w_s & r_s_d;
  assign w_edge     = w_rise | w_fall;
  assign w_timeout  = (r_state != IDLE) && !w_edge && (r_idle == CNT_W'(TIMEOUT - 1));
  assign w_complete = (r_state == LOW) && w_rise;
  assign w_per      = sat_add(r_hcnt, r_lcnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_idle  <= '0;
    end else begin
      if (r_state == IDLE || w_edge) r_idle <= '0;
      else                           r_idle <= r_idle + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_hcnt  <= CNT_W'(1);
            r_lcnt  <= '0;
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_state <= LOW;
            r_lcnt  <= CNT_W'(1);
          end else if (w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_hcnt <= sat_inc(r_hcnt);
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_hcnt  <= CNT_W'(1);
            r_lcnt  <= '0;
          end else if (w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_lcnt <= sat_inc(r_lcnt);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_sh = {r_rem, 1'b0};
  assign w_ge = (w_sh >= {1'b0, r_div});

  // Divider runs WIDTH shift/subtract steps, then one publish step; busy spans both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= 1'b0;
      r_step       <= '0;
      r_rem        <= '0;
      r_div        <= '0;
      r_ht         <= '0;
      r_quo        <= '0;
      r_duty       <= '0;
      r_high_time  <= '0;
      r_period     <= '0;
      r_duty_valid <= 1'b0;
      r_stuck      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      if (w_complete) begin
        if (r_busy) begin
          r_overrun <= 1'b1;
        end else begin
          r_busy <= 1'b1;
          r_step <= '0;
          r_rem  <= r_hcnt;
          r_div  <= w_per;
          r_ht   <= r_hcnt;
          r_quo  <= '0;
        end
      end
      if (r_busy) begin
        if (r_step == SW'(WIDTH)) begin
          r_busy       <= 1'b0;
          r_duty       <= r_quo;
          r_high_time  <= r_ht;
          r_period     <= r_div;
          r_duty_valid <= 1'b1;
          r_stuck      <= 1'b0;
        end else begin
          r_rem  <= CNT_W'(w_ge ? (w_sh - {1'b0, r_div}) : w_sh);
          r_quo  <= {r_quo[WIDTH-2:0], w_ge};
          r_step <= r_step + 1'b1;
        end
      end else if (w_timeout) begin
        r_duty       <= (r_state == HIGH) ? '1 : '0;
        r_high_time  <= (r_state == HIGH) ? CNT_W'(TIMEOUT) : '0;
        r_period     <= CNT_W'(TIMEOUT);
        r_duty_valid <= 1'b1;
        r_stuck      <= 1'b1;
      end
    end
  end

  assign duty       = r_duty;
  assign high_time  = r_high_time;
  assign period     = r_period;
  assign duty_valid = r_duty_valid;
  assign stuck      = r_stuck;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder: one instance with the default timeout,
// one with TIMEOUT=64 for the stuck-input scenario.
module tb_pwm_duty_decoder;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int SS    = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_a, pwm_b;
  logic [WIDTH-1:0] duty_a, duty_b;
  logic [CNT_W-1:0] ht_a, per_a, ht_b, per_b;
  logic             dv_a, dv_b, stuck_a, stuck_b, ovr_a, ovr_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int               strb_a = 0, strb_b = 0, strb_cyc_a = 0;
  logic [WIDTH-1:0] ld_a = '0, ld_b = '0;
  logic [CNT_W-1:0] lht_a = '0, lper_a = '0, lht_b = '0, lper_b = '0;
  logic             lst_a = 1'b0, lst_b = 1'b0;
  int               q_duty[$];
  int               q_per[$];

  pwm_duty_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(1024), .SYNC_STAGES(SS)) u_dut (
    .clk(clk), .rst(rst_n), .pwm_in(pwm_a), .duty(duty_a), .high_time(ht_a),
    .period(per_a), .duty_valid(dv_a), .stuck(stuck_a), .overrun(ovr_a));

  pwm_duty_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(64), .SYNC_STAGES(SS)) u_dut_to (
    .clk(clk), .rst(rst_n), .pwm_in(pwm_b), .duty(duty_b), .high_time(ht_b),
    .period(per_b), .duty_valid(dv_b), .stuck(stuck_b), .overrun(ovr_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      strb_a++; strb_cyc_a = cyc; ld_a = duty_a; lht_a = ht_a; lper_a = per_a; lst_a = stuck_a;
      q_duty.push_back(int'(duty_a)); q_per.push_back(int'(per_a));
    end
    if (dv_b === 1'b1) begin
      strb_b++; ld_b = duty_b; lht_b = ht_b; lper_b = per_b; lst_b = stuck_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int hi, input int lo, input bit on_b);
    if (on_b) pwm_b = 1'b1; else pwm_a = 1'b1;
    tick(hi);
    if (on_b) pwm_b = 1'b0; else pwm_a = 1'b0;
    tick(lo);
  endtask

  task automatic do_reset();
    pwm_a = 1'b0; pwm_b = 1'b0; rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    pwm_a = 1'b0; pwm_b = 1'b0; rst_n = 1'b0;
    tick(3);
    checks++; if (duty_a !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty_a); end
    checks++; if (ht_a !== 16'd0) begin errors++; $display("FAIL reset_high_time: got %0d want 0", ht_a); end
    checks++; if (per_a !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", per_a); end
    checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dv_a); end
    checks++; if (stuck_a !== 1'b0) begin errors++; $display("FAIL reset_stuck: got %b want 0", stuck_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", ovr_a); end
    checks++; if (duty_b !== 8'd0 || per_b !== 16'd0 || dv_b !== 1'b0) begin
      errors++; $display("FAIL reset_b: duty %0d period %0d valid %b want all 0", duty_b, per_b, dv_b);
    end
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_basic();
    int n0, t2;
    do_reset();
    n0 = strb_a;
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n0) begin errors++; $display("FAIL basic_first_rise: strobes %0d want %0d", strb_a - n0, 0); end
    t2 = cyc;
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n0 + 1) begin errors++; $display("FAIL basic_count: strobes %0d want 1", strb_a - n0); end
    checks++; if (ld_a !== 8'd64) begin errors++; $display("FAIL basic_duty: got %0d want 64", ld_a); end
    checks++; if (lht_a !== 16'd25) begin errors++; $display("FAIL basic_high_time: got %0d want 25", lht_a); end
    checks++; if (lper_a !== 16'd100) begin errors++; $display("FAIL basic_period: got %0d want 100", lper_a); end
    checks++; if (lst_a !== 1'b0) begin errors++; $display("FAIL basic_stuck: got %b want 0", lst_a); end
    checks++; if (strb_cyc_a - t2 !== SS + WIDTH + 2) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", strb_cyc_a - t2, SS + WIDTH + 2);
    end
    checks++; if (duty_a !== 8'd64 || ovr_a !== 1'b0) begin
      errors++; $display("FAIL basic_hold: duty %0d overrun %b want 64 / 0", duty_a, ovr_a);
    end
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n0 + 2 || ld_a !== 8'd64) begin
      errors++; $display("FAIL back_to_back: strobes %0d duty %0d want 2 / 64", strb_a - n0, ld_a);
    end
  endtask

  task automatic test_ratios();
    int hi_t[4]  = '{128, 1, 255, 1};
    int lo_t[4]  = '{128, 255, 1, 2};
    int exp_t[4] = '{128, 1, 255, 85};
    int n0;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      n0 = strb_a;
      pulse(hi_t[i], lo_t[i], 1'b0);
      pulse(hi_t[i], lo_t[i], 1'b0);
      tick(15);
      checks++; if (strb_a !== n0 + 1) begin
        errors++; $display("FAIL ratio%0d_count: strobes %0d want 1", i, strb_a - n0);
      end
      checks++; if (ld_a !== exp_t[i][WIDTH-1:0]) begin
        errors++; $display("FAIL ratio%0d_duty: got %0d want %0d", i, ld_a, exp_t[i]);
      end
      checks++; if (lper_a !== 16'(hi_t[i] + lo_t[i]) || lst_a !== 1'b0) begin
        errors++; $display("FAIL ratio%0d_period: got %0d stuck %b want %0d / 0", i, lper_a, lst_a, hi_t[i] + lo_t[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int n0;
    do_reset();
    n0 = strb_b;
    pwm_b = 1'b1;
    for (int i = 0; i < 200 && strb_b == n0; i++) tick(1);
    checks++; if (strb_b !== n0 + 1) begin errors++; $display("FAIL to_high_count: strobes %0d want 1", strb_b - n0); end
    checks++; if (ld_b !== 8'd255) begin errors++; $display("FAIL to_high_duty: got %0d want 255", ld_b); end
    checks++; if (lst_b !== 1'b1) begin errors++; $display("FAIL to_high_stuck: got %b want 1", lst_b); end
    checks++; if (lht_b !== 16'd64 || lper_b !== 16'd64) begin
      errors++; $display("FAIL to_high_times: high %0d period %0d want 64 / 64", lht_b, lper_b);
    end
    tick(5);
    checks++; if (stuck_b !== 1'b1) begin errors++; $display("FAIL to_stuck_hold: got %b want 1", stuck_b); end
    pwm_b = 1'b0;
    tick(100);
    checks++; if (strb_b !== n0 + 1) begin errors++; $display("FAIL to_idle_quiet: strobes %0d want 1", strb_b - n0); end
    pulse(20, 20, 1'b1);
    checks++; if (strb_b !== n0 + 1) begin errors++; $display("FAIL to_first_rise: strobes %0d want 1", strb_b - n0); end
    pulse(20, 20, 1'b1);
    checks++; if (strb_b !== n0 + 2 || ld_b !== 8'd128 || lst_b !== 1'b0) begin
      errors++; $display("FAIL to_recover: strobes %0d duty %0d stuck %b want 2 / 128 / 0", strb_b - n0, ld_b, lst_b);
    end
    tick(100);
    checks++; if (strb_b !== n0 + 3 || ld_b !== 8'd0 || lst_b !== 1'b1) begin
      errors++; $display("FAIL to_low: strobes %0d duty %0d stuck %b want 3 / 0 / 1", strb_b - n0, ld_b, lst_b);
    end
    checks++; if (lht_b !== 16'd0 || lper_b !== 16'd64) begin
      errors++; $display("FAIL to_low_times: high %0d period %0d want 0 / 64", lht_b, lper_b);
    end
  endtask

  task automatic test_overrun();
    int n0, bad;
    do_reset();
    n0 = strb_a;
    repeat (20) pulse(2, 2, 1'b0);
    tick(20);
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", ovr_a); end
    checks++; if (strb_a - n0 !== 7) begin errors++; $display("FAIL ovr_count: strobes %0d want 7", strb_a - n0); end
    bad = 0;
    for (int i = q_duty.size() - (strb_a - n0); i < q_duty.size(); i++)
      if (q_duty[i] != 128 || q_per[i] != 4) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovr_values: %0d strobes off, want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int n1;
    do_reset();
    pulse(25, 75, 1'b0);
    pulse(25, 75, 1'b0);
    checks++; if (duty_a !== 8'd64) begin errors++; $display("FAIL mid_pre_duty: got %0d want 64", duty_a); end
    pwm_a = 1'b1;
    tick(6);
    rst_n = 1'b0;
    #1;
    checks++; if (duty_a !== 8'd0 || ht_a !== 16'd0 || per_a !== 16'd0) begin
      errors++; $display("FAIL mid_async_clear: duty %0d high %0d period %0d want 0", duty_a, ht_a, per_a);
    end
    checks++; if (dv_a !== 1'b0 || stuck_a !== 1'b0 || ovr_a !== 1'b0) begin
      errors++; $display("FAIL mid_async_flags: valid %b stuck %b overrun %b want 0", dv_a, stuck_a, ovr_a);
    end
    n1 = strb_a;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(18);
    pwm_a = 1'b0;
    tick(75);
    checks++; if (strb_a !== n1) begin errors++; $display("FAIL mid_no_strobe: strobes %0d want 0", strb_a - n1); end
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n1) begin errors++; $display("FAIL mid_first_rise: strobes %0d want 0", strb_a - n1); end
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n1 + 1 || ld_a !== 8'd64) begin
      errors++; $display("FAIL mid_recover: strobes %0d duty %0d want 1 / 64", strb_a - n1, ld_a);
    end
  endtask

  task automatic test_release_high();
    int n0;
    pwm_a = 1'b1; rst_n = 1'b0;
    tick(3);
    n0 = strb_a;
    rst_n = 1'b1;
    tick(30);
    pwm_a = 1'b0;
    tick(10);
    checks++; if (strb_a !== n0 || duty_a !== 8'd0) begin
      errors++; $display("FAIL relhigh_idle: strobes %0d duty %0d want 0 / 0", strb_a - n0, duty_a);
    end
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n0) begin errors++; $display("FAIL relhigh_first_rise: strobes %0d want 0", strb_a - n0); end
    pulse(25, 75, 1'b0);
    checks++; if (strb_a !== n0 + 1 || ld_a !== 8'd64) begin
      errors++; $display("FAIL relhigh_second_rise: strobes %0d duty %0d want 1 / 64", strb_a - n0, ld_a);
    end
  endtask

  initial begin
    pwm_a = 1'b0; pwm_b = 1'b0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_ratios();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_release_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
